// File: rtl/vga_sync_gen_pkg.sv
// rtl/vga_sync_gen_pkg.sv - shared VGA timing constants, coordinate width and sync polarity
package vga_sync_gen_pkg;

   localparam int COORD_W = 10;
   localparam logic SYNC_ACTIVE = 1'b0;

   // 640x480 @ 60 Hz, 25 MHz pixel rate derived from a 100 MHz clock
   localparam int CLK_DIV_DEF   = 4;
   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;
   localparam int H_TOTAL_DEF   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOTAL_DEF   = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   function automatic logic in_window(input logic [COORD_W-1:0] c, input int lo, input int len);
      return (int'(c) >= lo) && (int'(c) < lo + len);
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - raster timing bundle from the sync generator to the pixel-colour path
interface vga_sync_gen_if;
   import vga_sync_gen_pkg::*;

   logic               hsync;
   logic               vsync;
   logic               video_on;
   logic               p_tick;
   logic               frame_end;
   logic [COORD_W-1:0] pixel_x;
   logic [COORD_W-1:0] pixel_y;

   modport master (
      output hsync, vsync, video_on, p_tick, frame_end, pixel_x, pixel_y
   );

   modport slave (
      input hsync, vsync, video_on, p_tick, frame_end, pixel_x, pixel_y
   );

endinterface

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// rtl/vga_sync_gen_pixel_tick_gen.sv - divides clk into a one-cycle pixel enable every CLK_DIV clocks
module pixel_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   generate
      if (CLK_DIV < 1) begin : g_div_check
         $error("pixel_tick_gen: CLK_DIV must be >= 1");
      end
   endgenerate

   logic [DIV_W-1:0] div_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Gated by reset so that CLK_DIV=1 does not tick while held in reset
   assign tick = !reset && (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster counters with zero-skew registered sync/blank decode
module vga_sync_gen
   import vga_sync_gen_pkg::*;
#(
   parameter int CLK_DIV   = CLK_DIV_DEF,
   parameter int H_DISPLAY = H_DISPLAY_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_DISPLAY = V_DISPLAY_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF
) (
   input  logic clk,
   input  logic reset,
   vga_sync_gen_if.master vga
);

   localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_DISPLAY + H_FRONT;
   localparam int VS_START = V_DISPLAY + V_FRONT;

   localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_DISPLAY);
   localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_DISPLAY);

   generate
      if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_size_check
         $error("vga_sync_gen: H_TOTAL or V_TOTAL exceeds the 10-bit counter range");
      end
   endgenerate

   logic               p_tick;
   logic [COORD_W-1:0] h;
   logic [COORD_W-1:0] v;
   logic [COORD_W-1:0] h_next;
   logic [COORD_W-1:0] v_next;
   logic               h_wrap;
   logic               v_wrap;
   logic               hsync_q;
   logic               vsync_q;
   logic               video_on_q;
   logic               frame_end_q;

   pixel_tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_pixel_tick_gen (
      .clk  (clk),
      .reset(reset),
      .tick (p_tick)
   );

   always_comb begin
      h_next = h;
      v_next = v;
      h_wrap = (h == H_LAST);
      v_wrap = (v == V_LAST);
      if (p_tick) begin
         h_next = h_wrap ? '0 : h + 1'b1;
         if (h_wrap) begin
            v_next = v_wrap ? '0 : v + 1'b1;
         end
      end
   end

   // Flags decode the next-state counts so they land in the same cycle as the coordinates
   always_ff @(posedge clk) begin
      if (reset) begin
         h           <= '0;
         v           <= '0;
         hsync_q     <= ~SYNC_ACTIVE;
         vsync_q     <= ~SYNC_ACTIVE;
         video_on_q  <= 1'b0;
         frame_end_q <= 1'b0;
      end else begin
         h           <= h_next;
         v           <= v_next;
         hsync_q     <= in_window(h_next, HS_START, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync_q     <= in_window(v_next, VS_START, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         video_on_q  <= (h_next < H_VIS) && (v_next < V_VIS);
         frame_end_q <= p_tick && h_wrap && v_wrap;
      end
   end

   assign vga.hsync     = hsync_q;
   assign vga.vsync     = vsync_q;
   assign vga.video_on  = video_on_q;
   assign vga.p_tick    = p_tick;
   assign vga.frame_end = frame_end_q;
   assign vga.pixel_x   = h;
   assign vga.pixel_y   = v;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench: default-timing and small-timing instances
module tb_vga_sync_gen;
   import vga_sync_gen_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;

   vga_sync_gen_if vga_a ();
   vga_sync_gen_if vga_b ();

   vga_sync_gen dut_a (
      .clk  (clk),
      .reset(rst_a),
      .vga  (vga_a)
   );

   vga_sync_gen #(
      .CLK_DIV(1),
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
   ) dut_b (
      .clk  (clk),
      .reset(rst_b),
      .vga  (vga_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cmp_state(input string name,
                            input logic [9:0] x, input logic [9:0] y,
                            input logic hs, input logic vs, input logic von, input logic fe,
                            input int ex, input int ey,
                            input bit ehs, input bit evs, input bit evon, input bit efe);
      logic [23:0] act;
      logic [23:0] exp;
      logic [9:0]  ex10;
      logic [9:0]  ey10;
      ex10 = ex[9:0];
      ey10 = ey[9:0];
      act  = {x, y, hs, vs, von, fe};
      exp  = {ex10, ey10, ehs, evs, evon, efe};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b von=%b fe=%b, expected x=%0d y=%0d hs=%b vs=%b von=%b fe=%b",
                  name, x, y, hs, vs, von, fe, ex, ey, ehs, evs, evon, efe);
      end
   endtask

   // Reference: after k edges since the last reset edge, floor(k/cd) pixels have elapsed
   task automatic model_check(input string tag, input int k, input bit inr, input logic rst_now,
                              input int cd, input int ht, input int vt, input int hd,
                              input int hs0, input int hsn, input int vd, input int vs0, input int vsn,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic hs, input logic vs, input logic von,
                              input logic pt, input logic fe);
      int ticks, pos, ex, ey;
      bit ehs, evs, evon, efe, ept;
      ticks = k / cd;
      pos   = ticks % (ht * vt);
      ex    = pos % ht;
      ey    = pos / ht;
      if (inr) begin
         ehs = 1'b1; evs = 1'b1; evon = 1'b0; efe = 1'b0;
      end else begin
         ehs  = !(ex >= hs0 && ex < hs0 + hsn);
         evs  = !(ey >= vs0 && ey < vs0 + vsn);
         evon = (ex < hd) && (ey < vd);
         efe  = (ticks > 0) && (k % cd == 0) && (pos == 0);
      end
      ept = (rst_now !== 1'b1) && (k % cd == cd - 1);
      cmp_state({tag, "_model"}, x, y, hs, vs, von, fe, ex, ey, ehs, evs, evon, efe);
      check({tag, "_p_tick"}, pt, ept);
   endtask

   int k_a = 0;
   int k_b = 0;
   bit inr_a = 1'b1;
   bit inr_b = 1'b1;
   bit chk_a = 1'b0;
   bit chk_b = 1'b0;

   always @(posedge clk) begin
      if (rst_a) begin k_a <= 0; inr_a <= 1'b1; end
      else begin k_a <= k_a + 1; inr_a <= 1'b0; end
      if (rst_b) begin k_b <= 0; inr_b <= 1'b1; end
      else begin k_b <= k_b + 1; inr_b <= 1'b0; end
   end

   always @(negedge clk) begin
      if (chk_a)
         model_check("a", k_a, inr_a, rst_a, 4, 800, 525, 640, 656, 96, 480, 490, 2,
                     vga_a.pixel_x, vga_a.pixel_y, vga_a.hsync, vga_a.vsync,
                     vga_a.video_on, vga_a.p_tick, vga_a.frame_end);
      if (chk_b)
         model_check("b", k_b, inr_b, rst_b, 1, 14, 7, 8, 10, 2, 4, 5, 1,
                     vga_b.pixel_x, vga_b.pixel_y, vga_b.hsync, vga_b.vsync,
                     vga_b.video_on, vga_b.p_tick, vga_b.frame_end);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int run;
      int ex;
      int ey;
      bit hs;
      bit vs;
      bit von;
      bit fe;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int edges, hs_low, hs_first_x, line_edge, von_cnt, vs_cnt, frames;
      bit von_in_sync, valid;

      rst_a = 1'b1;
      rst_b = 1'b1;

      // Default timing: reset held 5 clks
      repeat (5) begin
         step();
         check("a_rst_hsync", vga_a.hsync, 1);
         check("a_rst_vsync", vga_a.vsync, 1);
         check("a_rst_video_on", vga_a.video_on, 0);
         check("a_rst_p_tick", vga_a.p_tick, 0);
      end
      chk_a = 1'b1;
      rst_a = 1'b0;
      step();
      cmp_state("a_first_edge", vga_a.pixel_x, vga_a.pixel_y, vga_a.hsync, vga_a.vsync,
                vga_a.video_on, vga_a.frame_end, 0, 0, 1, 1, 1, 0);
      edges = 1;
      while (vga_a.pixel_x == 10'd0 && edges < 20) begin
         step();
         edges++;
      end
      check("a_first_tick_edge", edges, 4);

      hs_low = 0; hs_first_x = -1; line_edge = -1; von_in_sync = 1'b0;
      while (edges < 3600) begin
         step();
         edges++;
         if (vga_a.hsync == 1'b0) begin
            if (hs_first_x < 0) hs_first_x = int'(vga_a.pixel_x);
            hs_low++;
            if (vga_a.video_on) von_in_sync = 1'b1;
         end
         if (line_edge < 0 && vga_a.pixel_x == 10'd0 && vga_a.pixel_y == 10'd1) line_edge = edges;
      end
      check("a_hsync_low_clks", hs_low, 384);
      check("a_hsync_first_x", hs_first_x, 656);
      check("a_video_on_in_hsync", von_in_sync, 0);
      check("a_line_clks", line_edge, 3200);
      chk_a = 1'b0;
      rst_a = 1'b1;

      // Small timing table: H total 14, V total 7, one pixel per clk
      vecs.push_back('{0,   0,  0, 1, 1, 0, 0});
      vecs.push_back('{7,   7,  0, 1, 1, 1, 0});
      vecs.push_back('{8,   8,  0, 1, 1, 0, 0});
      vecs.push_back('{10, 10,  0, 0, 1, 0, 0});
      vecs.push_back('{11, 11,  0, 0, 1, 0, 0});
      vecs.push_back('{12, 12,  0, 1, 1, 0, 0});
      vecs.push_back('{13, 13,  0, 1, 1, 0, 0});
      vecs.push_back('{14,  0,  1, 1, 1, 1, 0});
      vecs.push_back('{56,  0,  4, 1, 1, 0, 0});
      vecs.push_back('{70,  0,  5, 1, 0, 0, 0});
      vecs.push_back('{83, 13,  5, 1, 0, 0, 0});
      vecs.push_back('{84,  0,  6, 1, 1, 0, 0});
      vecs.push_back('{97, 13,  6, 1, 1, 0, 0});
      vecs.push_back('{98,  0,  0, 1, 1, 1, 1});
      vecs.push_back('{99,  1,  0, 1, 1, 1, 0});
      vecs.push_back('{294, 0,  0, 1, 1, 1, 1});

      for (int i = 0; i < vecs.size(); i++) begin
         rst_b = 1'b1;
         repeat (2) step();
         chk_b = 1'b1;
         rst_b = 1'b0;
         repeat (vecs[i].run) step();
         cmp_state($sformatf("b_vec%0d_run%0d", i, vecs[i].run),
                   vga_b.pixel_x, vga_b.pixel_y, vga_b.hsync, vga_b.vsync,
                   vga_b.video_on, vga_b.frame_end,
                   vecs[i].ex, vecs[i].ey, vecs[i].hs, vecs[i].vs, vecs[i].von, vecs[i].fe);
      end

      // Mid-frame reset pulse for one clk, then resume
      rst_b = 1'b1;
      repeat (2) step();
      rst_b = 1'b0;
      repeat (47) step();
      cmp_state("b_pre_reset", vga_b.pixel_x, vga_b.pixel_y, vga_b.hsync, vga_b.vsync,
                vga_b.video_on, vga_b.frame_end, 5, 3, 1, 1, 1, 0);
      rst_b = 1'b1;
      step();
      rst_b = 1'b0;
      cmp_state("b_mid_reset", vga_b.pixel_x, vga_b.pixel_y, vga_b.hsync, vga_b.vsync,
                vga_b.video_on, vga_b.frame_end, 0, 0, 1, 1, 0, 0);
      step();
      cmp_state("b_resume", vga_b.pixel_x, vga_b.pixel_y, vga_b.hsync, vga_b.vsync,
                vga_b.video_on, vga_b.frame_end, 1, 0, 1, 1, 1, 0);
      repeat (97) step();
      cmp_state("b_resume_frame_end", vga_b.pixel_x, vga_b.pixel_y, vga_b.hsync, vga_b.vsync,
                vga_b.video_on, vga_b.frame_end, 0, 0, 1, 1, 1, 1);

      // Random reset pulses; whole frames must show 32 visible and 14 vsync clks
      valid = 1'b0; von_cnt = 0; vs_cnt = 0; frames = 0;
      for (int i = 0; i < 5000; i++) begin
         rst_b = ($urandom_range(0, 249) == 0);
         step();
         if (inr_b) begin
            valid = 1'b0; von_cnt = 0; vs_cnt = 0;
         end else begin
            if (vga_b.frame_end) begin
               if (valid) begin
                  check("b_frame_video_on_clks", von_cnt, 32);
                  check("b_frame_vsync_clks", vs_cnt, 14);
                  frames++;
               end
               valid = 1'b1; von_cnt = 0; vs_cnt = 0;
            end
            if (vga_b.video_on) von_cnt++;
            if (!vga_b.vsync) vs_cnt++;
         end
      end
      check("b_whole_frames_seen", frames > 10, 1);
      chk_b = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
